tx_fifo_pull: RTL and testbench

Transmit FIFO and pull controller for one PIO state machine. It buffers 32-bit words written by the system side in a 4-entry circular FIFO. It hands words to the downstream output shift register on explicit PULL instructions or on autopull when the shifter has consumed its threshold. It drives the shifter's load and count-clear strobes and the state machine's stall line.

---
 rtl/tx_fifo_pull_if.sv | 42 ++++
 rtl/tx_fifo_pull.sv | 116 +++++++++++
 tb/tb_tx_fifo_pull.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tx_fifo_pull_if.sv
// rtl/tx_fifo_pull_if.sv - system-write / shifter-handoff bundle for the TX FIFO pull controller
interface tx_fifo_pull_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic             penable;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             pull_req;
  logic             pull_block;
  logic             pull_ifempty;
  logic             autopull_en;
  logic [4:0]       pull_thresh;
  logic [6:0]       shift_count;
  logic [WIDTH-1:0] scratch_x;
  logic             flag_clr;
  logic [WIDTH-1:0] osr_data;
  logic             osr_set;
  logic             count_clr;
  logic             stall;
  logic             full;
  logic             empty;
  logic [LW-1:0]    level;
  logic             overflow;
  logic             stall_flag;

  modport master (
    output penable, wr_data, wr_en, pull_req, pull_block, pull_ifempty,
           autopull_en, pull_thresh, shift_count, scratch_x, flag_clr,
    input  osr_data, osr_set, count_clr, stall, full, empty, level,
           overflow, stall_flag
  );

  modport slave (
    input  penable, wr_data, wr_en, pull_req, pull_block, pull_ifempty,
           autopull_en, pull_thresh, shift_count, scratch_x, flag_clr,
    output osr_data, osr_set, count_clr, stall, full, empty, level,
           overflow, stall_flag
  );
endinterface

// File: rtl/tx_fifo_pull.sv
// rtl/tx_fifo_pull.sv - 4-entry TX FIFO with PULL/autopull handoff into the output shift register
module tx_fifo_pull #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           reset,
  tx_fifo_pull_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [LW-1:0]    r_level;
  logic             r_overflow;
  logic             r_stall_flag;

  logic             w_empty;
  logic             w_full;
  logic [6:0]       w_thr;
  logic             w_at_thr;
  logic             w_pop;
  logic             w_set;
  logic             w_sel_x;
  logic             w_stall;
  logic             w_stall_evt;
  logic             w_wr_accept;
  logic             w_ovf_evt;

  assign w_empty  = (r_level == '0);
  assign w_full   = (r_level == LW'(DEPTH));
  assign w_thr    = (bus.pull_thresh == 5'd0) ? 7'd32 : {2'b00, bus.pull_thresh};
  assign w_at_thr = (bus.shift_count >= w_thr);

  // Autopull and explicit PULL are OR-ed into one pop so a coincident pair consumes one word.
  always_comb begin
    w_pop       = 1'b0;
    w_set       = 1'b0;
    w_sel_x     = 1'b0;
    w_stall     = 1'b0;
    w_stall_evt = 1'b0;
    if (!reset && bus.penable) begin
      if (bus.autopull_en && w_at_thr && !w_empty) begin
        w_pop = 1'b1;
        w_set = 1'b1;
      end
      if (bus.pull_req) begin
        if (bus.pull_ifempty && !w_at_thr) begin
          w_stall = 1'b0;
        end else if (bus.autopull_en && w_at_thr && w_empty) begin
          w_stall     = bus.pull_block;
          w_stall_evt = bus.pull_block;
        end else if (!w_empty) begin
          w_pop = 1'b1;
          w_set = 1'b1;
        end else if (bus.pull_block) begin
          w_stall     = 1'b1;
          w_stall_evt = 1'b1;
        end else begin
          w_sel_x = 1'b1;
          w_set   = 1'b1;
        end
      end
    end
  end

  // A pop frees the slot on the same edge, so a write into a full FIFO is still taken.
  assign w_wr_accept = bus.wr_en && (!w_full || w_pop);
  assign w_ovf_evt   = bus.wr_en && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
      r_stall_flag <= 1'b0;
    end else begin
      if (w_wr_accept) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_level <= r_level + LW'(w_wr_accept) - LW'(w_pop);
      if (w_ovf_evt) begin
        r_overflow <= 1'b1;
      end else if (bus.flag_clr) begin
        r_overflow <= 1'b0;
      end
      if (w_stall_evt) begin
        r_stall_flag <= 1'b1;
      end else if (bus.flag_clr) begin
        r_stall_flag <= 1'b0;
      end
    end
  end

  assign bus.osr_data   = w_sel_x ? bus.scratch_x : r_mem[r_rd_ptr];
  assign bus.osr_set    = w_set;
  assign bus.count_clr  = w_set;
  assign bus.stall      = w_stall;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.level      = r_level;
  assign bus.overflow   = r_overflow;
  assign bus.stall_flag = r_stall_flag;
endmodule

// File: tb/tb_tx_fifo_pull.sv
// tb/tb_tx_fifo_pull.sv - directed vector bench for tx_fifo_pull
module tb_tx_fifo_pull;
  logic clk;
  logic reset;

  tx_fifo_pull_if #(.DEPTH(4), .WIDTH(32)) bus ();

  tx_fifo_pull #(.DEPTH(4), .WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [31:0] wd;
    logic        pen;
    logic        pr;
    logic        pb;
    logic        pie;
    logic        ape;
    logic [4:0]  thr;
    logic [6:0]  sc;
    logic [31:0] sx;
    logic        fc;
    logic        e_set;
    logic [31:0] e_data;
    logic        e_stall;
    logic [2:0]  e_lvl;
    logic        e_ovf;
    logic        e_sf;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;

  function automatic vec_t v(
    input logic rst, input logic we, input logic [31:0] wd, input logic pen,
    input logic pr, input logic pb, input logic pie, input logic ape,
    input logic [4:0] thr, input logic [6:0] sc, input logic [31:0] sx, input logic fc,
    input logic e_set, input logic [31:0] e_data, input logic e_stall,
    input logic [2:0] e_lvl, input logic e_ovf, input logic e_sf);
    vec_t r;
    r.rst = rst; r.we = we; r.wd = wd; r.pen = pen; r.pr = pr; r.pb = pb;
    r.pie = pie; r.ape = ape; r.thr = thr; r.sc = sc; r.sx = sx; r.fc = fc;
    r.e_set = e_set; r.e_data = e_data; r.e_stall = e_stall;
    r.e_lvl = e_lvl; r.e_ovf = e_ovf; r.e_sf = e_sf;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, step_no, act, exp);
    end
  endtask

  task automatic step(input vec_t t);
    @(negedge clk);
    reset            = t.rst;
    bus.wr_en        = t.we;
    bus.wr_data      = t.wd;
    bus.penable      = t.pen;
    bus.pull_req     = t.pr;
    bus.pull_block   = t.pb;
    bus.pull_ifempty = t.pie;
    bus.autopull_en  = t.ape;
    bus.pull_thresh  = t.thr;
    bus.shift_count  = t.sc;
    bus.scratch_x    = t.sx;
    bus.flag_clr     = t.fc;
    #1;
    chk("osr_set", 32'(bus.osr_set), 32'(t.e_set));
    chk("count_clr", 32'(bus.count_clr), 32'(t.e_set));
    chk("stall", 32'(bus.stall), 32'(t.e_stall));
    if (t.e_set) chk("osr_data", bus.osr_data, t.e_data);
    @(posedge clk);
    #1;
    chk("level", 32'(bus.level), 32'(t.e_lvl));
    chk("full", 32'(bus.full), 32'(t.e_lvl == 3'd4));
    chk("empty", 32'(bus.empty), 32'(t.e_lvl == 3'd0));
    chk("overflow", 32'(bus.overflow), 32'(t.e_ovf));
    chk("stall_flag", 32'(bus.stall_flag), 32'(t.e_sf));
    step_no++;
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 0; bus.wr_data = 0; bus.penable = 0; bus.pull_req = 0;
    bus.pull_block = 0; bus.pull_ifempty = 0; bus.autopull_en = 0;
    bus.pull_thresh = 0; bus.shift_count = 0; bus.scratch_x = 0; bus.flag_clr = 0;

    //          rst we wd            pen pr pb pie ape thr sc  sx            fc   set data          stl lvl ovf sf
    vecs.push_back(v(1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 0, 0, 0));
    vecs.push_back(v(0, 1, 32'h11111111, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 1, 0, 0));
    vecs.push_back(v(0, 1, 32'h22222222, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 2, 0, 0));
    vecs.push_back(v(0, 1, 32'h33333333, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 3, 0, 0));
    vecs.push_back(v(0, 1, 32'h44444444, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 4, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   1, 32'h11111111, 0, 3, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   1, 32'h22222222, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   1, 32'h33333333, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   1, 32'h44444444, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 32'hA0000001, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 1, 0, 0));
    vecs.push_back(v(0, 1, 32'hA0000002, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 2, 0, 0));
    vecs.push_back(v(0, 1, 32'hA0000003, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 3, 0, 0));
    vecs.push_back(v(0, 1, 32'hA0000004, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 4, 0, 0));
    vecs.push_back(v(0, 1, 32'hA0000005, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 4, 1, 0));
    vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  32'h0,        1,   0, 32'h0,        0, 4, 0, 0));
    vecs.push_back(v(0, 1, 32'hA0000006, 1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   1, 32'hA0000001, 0, 4, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   1, 32'hA0000002, 0, 3, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   1, 32'hA0000003, 0, 2, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   1, 32'hA0000004, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   1, 32'hA0000006, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        1, 0, 0, 1));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        1, 0, 0, 1));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        1, 0, 0, 1));
    vecs.push_back(v(0, 1, 32'hDEADBEEF, 1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        1, 1, 0, 1));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   1, 32'hDEADBEEF, 0, 0, 0, 1));
    vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  32'h0,        1,   0, 32'h0,        0, 0, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        1,   0, 32'h0,        1, 0, 0, 1));
    vecs.push_back(v(0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0,  32'h0,        1,   0, 32'h0,        0, 0, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 0, 0, 0, 0, 0,  32'hCAFEF00D, 0,   1, 32'hCAFEF00D, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        0, 1, 1, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 0, 0, 0));
    vecs.push_back(v(0, 1, 32'hB0000001, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 1, 0, 0));
    vecs.push_back(v(0, 1, 32'hB0000002, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 2, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 0, 0, 0, 1, 8, 7,  32'h0,        0,   0, 32'h0,        0, 2, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 0, 0, 0, 1, 8, 8,  32'h0,        0,   1, 32'hB0000001, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 0, 0, 0, 1, 0, 31, 32'h0,        0,   0, 32'h0,        0, 1, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 0, 0, 0, 1, 0, 32, 32'h0,        0,   1, 32'hB0000002, 0, 0, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 1, 8, 8,  32'h0,        0,   0, 32'h0,        1, 0, 0, 1));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 0, 0, 1, 8, 8,  32'h12345678, 1,   0, 32'h0,        0, 0, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 1, 0, 8, 0,  32'h0,        0,   0, 32'h0,        0, 0, 0, 0));
    vecs.push_back(v(0, 1, 32'hC0000001, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 1, 0, 0));
    vecs.push_back(v(0, 1, 32'hC0000002, 0, 0, 0, 0, 0, 0, 0,  32'h0,        0,   0, 32'h0,        0, 2, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 1, 8, 8,  32'h0,        0,   1, 32'hC0000001, 0, 1, 0, 0));
    vecs.push_back(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0,  32'h0,        0,   1, 32'hC0000002, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i]);
    end

    // Reset while a blocking pull is pending on a FIFO holding three words.
    step(v(0, 1, 32'hD0000001, 1, 1, 1, 0, 0, 0, 0, 32'h0, 0,   0, 32'h0, 1, 1, 0, 1));
    step(v(0, 1, 32'hD0000002, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0,   0, 32'h0, 0, 2, 0, 1));
    step(v(0, 1, 32'hD0000003, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0,   0, 32'h0, 0, 3, 0, 1));
    step(v(1, 1, 32'hD0000004, 1, 1, 1, 0, 0, 0, 0, 32'h0, 0,   0, 32'h0, 0, 0, 0, 0));
    step(v(0, 1, 32'hE0000001, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0,   0, 32'h0, 0, 1, 0, 0));
    step(v(0, 0, 32'h0,        1, 1, 1, 0, 0, 0, 0, 32'h0, 0,   1, 32'hE0000001, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
